// File: rtl/cntr3_down.sv
// Modulo-MOD down counter with synchronous load, registered zero flag and borrow pulse on wrap.
// Define CNTR3_DOWN_STOP_EN for stop mode: counting halts at 0 and borrow stays low.

module cntr3_down_next #(
    parameter int WIDTH = 2,
    parameter int MOD   = 3
) (
    input  logic [WIDTH-1:0] cnt_q,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] cnt_d,
    output logic             zero_d,
    output logic             borrow_d
);
    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MOD - 1);

    always_comb begin
        cnt_d    = cnt_q;
        borrow_d = 1'b0;
        if (load) begin
            cnt_d = (load_val > CNT_MAX) ? CNT_MAX : load_val;
        end else if (cnt_q > CNT_MAX) begin
            // out-of-range count recovers to the top of the range on any non-load cycle
            cnt_d = CNT_MAX;
        end else if (dec) begin
            if (cnt_q == '0) begin
`ifdef CNTR3_DOWN_STOP_EN
                cnt_d = '0;
`else
                cnt_d    = CNT_MAX;
                borrow_d = 1'b1;
`endif
            end else begin
                cnt_d = cnt_q - WIDTH'(1);
            end
        end
        zero_d = (cnt_d == '0);
    end
endmodule

module cntr3_down_reg #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] cnt_d,
    input  logic             zero_d,
    input  logic             borrow_d,
    output logic [WIDTH-1:0] cnt_q,
    output logic             zero_q,
    output logic             borrow_q
);
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            zero_q   <= 1'b1;
            borrow_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            zero_q   <= zero_d;
            borrow_q <= borrow_d;
        end
    end
endmodule

module cntr3_down_out #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] cnt_q,
    input  logic             zero_q,
    input  logic             borrow_q,
    output logic [WIDTH-1:0] cnt,
    output logic             zero,
    output logic             borrow
);
    always_comb begin
        cnt    = cnt_q;
        zero   = zero_q;
        borrow = borrow_q;
    end
endmodule

module cntr3_down #(
    parameter int WIDTH = 2,
    parameter int MOD   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] cnt,
    output logic             zero,
    output logic             borrow
);
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] cnt_q;
    logic             zero_d;
    logic             zero_q;
    logic             borrow_d;
    logic             borrow_q;

    cntr3_down_next #(.WIDTH(WIDTH), .MOD(MOD)) u_next (
        .cnt_q    (cnt_q),
        .load     (load),
        .load_val (load_val),
        .dec      (dec),
        .cnt_d    (cnt_d),
        .zero_d   (zero_d),
        .borrow_d (borrow_d)
    );

    cntr3_down_reg #(.WIDTH(WIDTH)) u_reg (
        .clk      (clk),
        .reset    (reset),
        .cnt_d    (cnt_d),
        .zero_d   (zero_d),
        .borrow_d (borrow_d),
        .cnt_q    (cnt_q),
        .zero_q   (zero_q),
        .borrow_q (borrow_q)
    );

    cntr3_down_out #(.WIDTH(WIDTH)) u_out (
        .cnt_q    (cnt_q),
        .zero_q   (zero_q),
        .borrow_q (borrow_q),
        .cnt      (cnt),
        .zero     (zero),
        .borrow   (borrow)
    );
endmodule

// File: tb/tb_cntr3_down.sv
// Scoreboard bench for cntr3_down: default MOD=3/WIDTH=2 instance plus a WIDTH=3/MOD=5 instance.
// Expectations follow CNTR3_DOWN_STOP_EN when the bench is built with it.

module tb_cntr3_down;
`ifdef CNTR3_DOWN_STOP_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    typedef struct {
        string tag;
        int    sel;
        int    cnt;
        int    zero;
        int    borrow;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst0 = 1'b0, ld0 = 1'b0, dc0 = 1'b0;
    logic [1:0] lv0 = '0;
    logic [1:0] cnt0;
    logic       zero0, borrow0;
    logic       rst1 = 1'b0, ld1 = 1'b0, dc1 = 1'b0;
    logic [2:0] lv1 = '0;
    logic [2:0] cnt1;
    logic       zero1, borrow1;

    exp_t exp_q[$];
    int   m_cnt[2] = '{0, 0};
    int   n_vec = 0;
    int   n_miscomp = 0;
    int   borrow_seen;
    int   max_seen;

    always #5 clk = ~clk;

    cntr3_down #(.WIDTH(2), .MOD(3)) dut (
        .clk(clk), .reset(rst0), .load(ld0), .load_val(lv0), .dec(dc0),
        .cnt(cnt0), .zero(zero0), .borrow(borrow0)
    );

    cntr3_down #(.WIDTH(3), .MOD(5)) dut5 (
        .clk(clk), .reset(rst1), .load(ld1), .load_val(lv1), .dec(dc1),
        .cnt(cnt1), .zero(zero1), .borrow(borrow1)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscomp++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, push the model's prediction, then compare after the edge.
    task automatic step(input int sel, input string tag, input bit rst, input bit ld,
                        input int lv, input bit dc);
        exp_t e;
        int   mx;
        int   c;
        int   b;
        mx = (sel == 1) ? 4 : 2;
        c  = m_cnt[sel];
        b  = 0;
        @(negedge clk);
        if (sel == 0) begin
            rst0 = rst; ld0 = ld; lv0 = 2'(lv); dc0 = dc;
        end else begin
            rst1 = rst; ld1 = ld; lv1 = 3'(lv); dc1 = dc;
        end
        if (rst)          c = 0;
        else if (ld)      c = (lv > mx) ? mx : lv;
        else if (dc) begin
            if (c == 0) begin
                if (!STOP) begin
                    c = mx;
                    b = 1;
                end
            end else begin
                c = c - 1;
            end
        end
        m_cnt[sel] = c;
        e.tag = tag; e.sel = sel; e.cnt = c; e.zero = (c == 0) ? 1 : 0; e.borrow = b;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        if (e.sel == 0) begin
            check_val({e.tag, ".cnt"},    int'(cnt0),    e.cnt);
            check_val({e.tag, ".zero"},   int'(zero0),   e.zero);
            check_val({e.tag, ".borrow"}, int'(borrow0), e.borrow);
            borrow_seen += int'(borrow0);
            if (int'(cnt0) > max_seen) max_seen = int'(cnt0);
        end else begin
            check_val({e.tag, ".cnt"},    int'(cnt1),    e.cnt);
            check_val({e.tag, ".zero"},   int'(zero1),   e.zero);
            check_val({e.tag, ".borrow"}, int'(borrow1), e.borrow);
            borrow_seen += int'(borrow1);
            if (int'(cnt1) > max_seen) max_seen = int'(cnt1);
        end
    endtask

    initial begin
        // reset overrides load and dec
        for (int i = 0; i < 2; i++) step(0, "reset", 1'b1, 1'b1, 3, 1'b1);

        borrow_seen = 0;
        for (int i = 0; i < 7; i++) step(0, "freerun", 1'b0, 1'b0, 0, 1'b1);
        check_val("freerun_borrows", borrow_seen, STOP ? 0 : 3);

        step(0, "load1",     1'b0, 1'b1, 1, 1'b0);
        step(0, "load_clamp", 1'b0, 1'b1, 3, 1'b0);
        step(0, "load_win",  1'b0, 1'b1, 0, 1'b1);
        step(0, "load2",     1'b0, 1'b1, 2, 1'b0);
        step(0, "dec_mid",   1'b0, 1'b0, 0, 1'b1);

        borrow_seen = 0;
        for (int i = 0; i < 5; i++) step(0, "hold", 1'b0, 1'b0, 0, 1'b0);
        check_val("hold_borrows", borrow_seen, 0);
        step(0, "reset_mid", 1'b1, 1'b0, 0, 1'b1);

        borrow_seen = 0;
        step(0, "stop_load", 1'b0, 1'b1, 2, 1'b0);
        for (int i = 0; i < 5; i++) step(0, "stop_dec", 1'b0, 1'b0, 0, 1'b1);
        check_val("stop_borrows", borrow_seen, STOP ? 0 : 1);
        step(0, "stop_reload", 1'b0, 1'b1, 2, 1'b0);

        step(1, "m5_reset", 1'b1, 1'b0, 0, 1'b0);
        borrow_seen = 0;
        max_seen = 0;
        for (int i = 0; i < 10; i++) step(1, "m5_dec", 1'b0, 1'b0, 0, 1'b1);
        check_val("m5_borrows", borrow_seen, STOP ? 0 : 2);
        check_val("m5_max_cnt", max_seen, STOP ? 0 : 4);
        step(1, "m5_clamp",  1'b0, 1'b1, 7, 1'b0);
        step(1, "m5_load3",  1'b0, 1'b1, 3, 1'b1);
        step(1, "m5_dec3",   1'b0, 1'b0, 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscomp);
        $finish;
    end
endmodule
